vga_region_scanner: RTL and testbench

VGA_REGION_SCANNER -- requirements
Module: vga_region_scanner

---
 rtl/vga_region_scanner.sv | 199 +++++++++++++++++++
 tb/tb_vga_region_scanner.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_region_scanner.sv
// VGA timing generator with double-buffered rectangular region windows.
// Define VGA_REGION_MIRROR_EN to build per-region horizontal mirroring.
module vga_region_scanner #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int NUM_REGIONS = 4,
  parameter int COL_W       = 10,
  parameter int ROW_W       = 9,
  parameter int ADDR_W      = 19
) (
  input  logic                   iVGA_CLK,
  input  logic                   iRST_n,
  output logic                   oHS,
  output logic                   oVS,
  output logic                   oBLANK_n,
  output logic [ROW_W-1:0]       row,
  output logic [COL_W-1:0]       col,
  output logic                   frame_tick,
  output logic [NUM_REGIONS-1:0] region_hit,
  output logic                   region_any,
  output logic [3:0]             region_sel,
  output logic [ADDR_W-1:0]      region_addr,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [3:0]             cfg_idx,
  input  logic [COL_W-1:0]       cfg_x0,
  input  logic [ROW_W-1:0]       cfg_y0,
  input  logic [COL_W-1:0]       cfg_w,
  input  logic [ROW_W-1:0]       cfg_h,
  input  logic                   cfg_mirror
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_B   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_E   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_B   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_E   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  typedef struct packed {
    logic [COL_W-1:0] x0;
    logic [ROW_W-1:0] y0;
    logic [COL_W-1:0] w;
    logic [ROW_W-1:0] h;
`ifdef VGA_REGION_MIRROR_EN
    logic             mir;
`endif
  } rgn_t;

  logic [HW-1:0]          hcnt_q, hcnt_d;
  logic [VW-1:0]          vcnt_q, vcnt_d;
  rgn_t                   shd_q [NUM_REGIONS];
  rgn_t                   act_q [NUM_REGIONS];
  logic [ADDR_W-1:0]      lb_q  [NUM_REGIONS];

  logic                   hs_q, vs_q, blank_q;
  logic [ROW_W-1:0]       row_q;
  logic [COL_W-1:0]       col_q;
  logic                   tick_q, rdy_q, any_q;
  logic [NUM_REGIONS-1:0] hit_q;
  logic [3:0]             sel_q;
  logic [ADDR_W-1:0]      addr_q;

  logic                   h_last, v_last;
  logic                   vrow, vis, tick_c;
  logic [ROW_W-1:0]       rv;
  logic [COL_W-1:0]       col_c;
  logic [NUM_REGIONS-1:0] rin, hit_c;
  logic [COL_W-1:0]       off_c  [NUM_REGIONS];
  logic [ADDR_W-1:0]      addr_c [NUM_REGIONS];
  logic [3:0]             sel_d;
  logic [ADDR_W-1:0]      addr_d;
  rgn_t                   wr_d;

  always_comb begin
    wr_d.x0 = cfg_x0;
    wr_d.y0 = cfg_y0;
    wr_d.w  = cfg_w;
    wr_d.h  = cfg_h;
`ifdef VGA_REGION_MIRROR_EN
    wr_d.mir = cfg_mirror;
`endif
  end

`ifndef VGA_REGION_MIRROR_EN
  logic unused_cfg_mirror;
  assign unused_cfg_mirror = cfg_mirror;
`endif

  always_comb begin
    h_last = hcnt_q == H_LAST;
    v_last = vcnt_q == V_LAST;
    hcnt_d = h_last ? '0 : hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (h_last) vcnt_d = v_last ? '0 : vcnt_q + 1'b1;
    vrow   = vcnt_q < V_ACT;
    vis    = vrow && (hcnt_q < H_ACT);
    rv     = ROW_W'(vcnt_q);
    col_c  = vis ? COL_W'(hcnt_q) : '0;
    tick_c = (hcnt_q == '0) && (vcnt_q == V_ACT);
  end

  // Line base holds (row-y0)*w; only the in-row offset is added here.
  always_comb begin
    for (int i = 0; i < NUM_REGIONS; i++) begin
      rin[i] = (act_q[i].w != '0) && (act_q[i].h != '0) && vrow
        && ({1'b0, rv} >= {1'b0, act_q[i].y0})
        && ({1'b0, rv} < {1'b0, act_q[i].y0} + {1'b0, act_q[i].h});
      hit_c[i] = rin[i] && vis
        && ({1'b0, col_c} >= {1'b0, act_q[i].x0})
        && ({1'b0, col_c} < {1'b0, act_q[i].x0} + {1'b0, act_q[i].w});
      off_c[i] = col_c - act_q[i].x0;
`ifdef VGA_REGION_MIRROR_EN
      if (act_q[i].mir) off_c[i] = act_q[i].w - COL_W'(1) - off_c[i];
`endif
      addr_c[i] = lb_q[i] + ADDR_W'(off_c[i]);
    end
    sel_d  = '0;
    addr_d = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (hit_c[i]) begin
        sel_d  = 4'(i);
        addr_d = addr_c[i];
      end
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      tick_q  <= 1'b0;
      rdy_q   <= 1'b0;
      hit_q   <= '0;
      any_q   <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
        shd_q[i] <= '0;
        act_q[i] <= '0;
        lb_q[i]  <= '0;
      end
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      hs_q    <= !((hcnt_q >= HS_B) && (hcnt_q < HS_E));
      vs_q    <= !((vcnt_q >= VS_B) && (vcnt_q < VS_E));
      blank_q <= vis;
      row_q   <= vis ? rv : '0;
      col_q   <= col_c;
      tick_q  <= tick_c;
      rdy_q   <= !tick_c;
      hit_q   <= hit_c;
      any_q   <= |hit_c;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (h_last) begin
          if (v_last) lb_q[i] <= '0;
          else if (rin[i]) lb_q[i] <= lb_q[i] + ADDR_W'(act_q[i].w);
        end
        // Commit happens while cfg_ready is low, so no write races it.
        if (tick_q) act_q[i] <= shd_q[i];
        if (cfg_valid && rdy_q && (cfg_idx == 4'(i))) shd_q[i] <= wr_d;
      end
    end
  end

  assign oHS         = hs_q;
  assign oVS         = vs_q;
  assign oBLANK_n    = blank_q;
  assign row         = row_q;
  assign col         = col_q;
  assign frame_tick  = tick_q;
  assign cfg_ready   = rdy_q;
  assign region_hit  = hit_q;
  assign region_any  = any_q;
  assign region_sel  = sel_q;
  assign region_addr = addr_q;

endmodule

// File: tb/tb_vga_region_scanner.sv
// Bench for vga_region_scanner on a reduced timing: every cycle is
// compared with a pixel-level model driven by random region setups.
module tb_vga_region_scanner;

  localparam int HA = 128, HF = 8, HS = 16, HB = 8;
  localparam int VA = 48, VF = 3, VS = 2, VB = 6;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam int NR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          oHS, oVS, oBLANK_n;
  logic [8:0]    row;
  logic [9:0]    col;
  logic          frame_tick;
  logic [NR-1:0] region_hit;
  logic          region_any;
  logic [3:0]    region_sel;
  logic [18:0]   region_addr;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [3:0]    cfg_idx;
  logic [9:0]    cfg_x0;
  logic [8:0]    cfg_y0;
  logic [9:0]    cfg_w;
  logic [8:0]    cfg_h;
  logic          cfg_mirror;

  vga_region_scanner #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .NUM_REGIONS(NR), .COL_W(10), .ROW_W(9), .ADDR_W(19)
  ) dut (
    .iVGA_CLK(clk), .iRST_n(rst_n),
    .oHS(oHS), .oVS(oVS), .oBLANK_n(oBLANK_n),
    .row(row), .col(col), .frame_tick(frame_tick),
    .region_hit(region_hit), .region_any(region_any),
    .region_sel(region_sel), .region_addr(region_addr),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_idx(cfg_idx), .cfg_x0(cfg_x0), .cfg_y0(cfg_y0),
    .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_mirror(cfg_mirror)
  );

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          blank;
    logic [8:0]    row;
    logic [9:0]    col;
    logic          tick;
    logic [NR-1:0] hit;
    logic          any;
    logic [3:0]    sel;
    logic [18:0]   addr;
    logic          rdy;
  } obs_t;

  typedef struct {
    int x0; int y0; int w; int h; bit mir;
  } rg_t;

  rg_t  shd [NR];
  rg_t  act [NR];
  int   checks = 0;
  int   failures = 0;
  int   n = 0;
  obs_t rst_e;

  function automatic bit inside_rg(rg_t r, int c, int v);
    return r.w > 0 && r.h > 0 && c >= r.x0 && c < r.x0 + r.w
      && v >= r.y0 && v < r.y0 + r.h;
  endfunction

  function automatic int addr_of(rg_t r, int c, int v);
    int dx = c - r.x0;
`ifdef VGA_REGION_MIRROR_EN
    if (r.mir) dx = r.w - 1 - dx;
`endif
    return (v - r.y0) * r.w + dx;
  endfunction

  // Expected outputs for flat pixel index p since reset release.
  function automatic obs_t model(int p);
    obs_t e;
    int   hc = p % HT;
    int   vc = (p / HT) % VT;
    bit   vis = hc < HA && vc < VA;
    e = '0;
    e.hs    = !(hc >= HA + HF && hc < HA + HF + HS);
    e.vs    = !(vc >= VA + VF && vc < VA + VF + VS);
    e.blank = vis;
    e.row   = vis ? 9'(vc) : 9'd0;
    e.col   = vis ? 10'(hc) : 10'd0;
    e.tick  = hc == 0 && vc == VA;
    e.rdy   = !e.tick;
    for (int i = NR - 1; i >= 0; i--) begin
      if (vis && inside_rg(act[i], hc, vc)) begin
        e.hit[i] = 1'b1;
        e.sel    = 4'(i);
        e.addr   = 19'(addr_of(act[i], hc, vc));
      end
    end
    e.any = |e.hit;
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.hs    = oHS;
    o.vs    = oVS;
    o.blank = oBLANK_n;
    o.row   = row;
    o.col   = col;
    o.tick  = frame_tick;
    o.hit   = region_hit;
    o.any   = region_any;
    o.sel   = region_sel;
    o.addr  = region_addr;
    o.rdy   = cfg_ready;
    return o;
  endfunction

  task automatic check(string tag, obs_t o, obs_t e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, o, e);
    end
  endtask

  task automatic step();
    obs_t e;
    @(posedge clk);
    #1;
    n++;
    e = model(n - 1);
    check("pix", sample(), e);
    if (e.tick) for (int i = 0; i < NR; i++) act[i] = shd[i];
  endtask

  task automatic run_to(int target);
    while (n < target) step();
  endtask

  task automatic cfg_write(int idx, int x0, int y0, int w, int h, bit m);
    bit acc;
    cfg_valid  = 1'b1;
    cfg_idx    = 4'(idx);
    cfg_x0     = 10'(x0);
    cfg_y0     = 9'(y0);
    cfg_w      = 10'(w);
    cfg_h      = 9'(h);
    cfg_mirror = m;
    for (int k = 0; k < 4; k++) begin
      acc = (n > 0) && model(n - 1).rdy;
      if (acc && idx < NR) shd[idx] = '{x0, y0, w, h, m};
      step();
      if (acc) break;
    end
    cfg_valid = 1'b0;
  endtask

  task automatic do_reset(int cycles);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) begin
      shd[i] = '{0, 0, 0, 0, 1'b0};
      act[i] = '{0, 0, 0, 0, 1'b0};
    end
    check("rst_async", sample(), rst_e);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      check("rst_hold", sample(), rst_e);
    end
    rst_n = 1'b1;
    n = 0;
  endtask

  initial begin
    rst_e = '0;
    rst_e.hs = 1'b1;
    rst_e.vs = 1'b1;
    cfg_valid = 1'b0;
    cfg_idx = '0;
    cfg_x0 = '0;
    cfg_y0 = '0;
    cfg_w = '0;
    cfg_h = '0;
    cfg_mirror = 1'b0;
    rst_n = 1'b1;
    #2;
    do_reset(3);

    // Frame 0: program shadows; first write to 0 is superseded.
    repeat (3) step();
    cfg_write(0, 7, 7, 5, 5, 1'b1);
    cfg_write(int'($urandom_range(4, 15)), 0, 0, HA, VA, 1'b0);
    cfg_write(0, 10, 10, 40, 30, 1'(($urandom_range(0, 1))));
    cfg_write(1, int'($urandom_range(20, 45)),
      int'($urandom_range(15, 35)), int'($urandom_range(10, 90)),
      int'($urandom_range(5, 30)), 1'($urandom_range(0, 1)));
    cfg_write(2, 100, int'($urandom_range(0, 40)), 50,
      int'($urandom_range(1, 20)), 1'($urandom_range(0, 1)));
    cfg_write(3, int'($urandom_range(0, 100)),
      int'($urandom_range(0, 40)), 0, int'($urandom_range(1, 20)),
      1'($urandom_range(0, 1)));

    // Frame 1: mid-frame rewrites only show up in frame 2.
    run_to(FR + 20 * HT);
    cfg_write(2, int'($urandom_range(0, 120)),
      int'($urandom_range(0, 47)), int'($urandom_range(1, 60)),
      int'($urandom_range(1, 47)), 1'($urandom_range(0, 1)));
    cfg_write(3, int'($urandom_range(0, 120)),
      int'($urandom_range(0, 47)), int'($urandom_range(1, 60)),
      int'($urandom_range(1, 47)), 1'($urandom_range(0, 1)));

    // Frame 2: uncommitted write then a mid-frame reset drops it.
    run_to(2 * FR + 30 * HT);
    cfg_write(1, 0, 0, HA, VA, 1'b0);
    do_reset(2);
    run_to(FR + VA * HT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
